// File: rtl/pc8001m_pkg.sv
// Shared types and limits for the PC8001M main-RAM arbiter and its row buffer.
// No logic, no latency, no flow control.
// Holds the FSM state encoding, default row length and RAM latency bounds.
package pc8001m_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU,
        ST_CWAIT,
        ST_DMA,
        ST_DRAIN
    } state_t;

    localparam int ROW_BYTES_DEF = 120;
    localparam int RAM_LAT_DEF   = 1;
    localparam int RAM_LAT_MIN   = 1;
    localparam int RAM_LAT_MAX   = 3;

    function automatic int clamp_lat(input int lat);
        if (lat < RAM_LAT_MIN) return RAM_LAT_MIN;
        if (lat > RAM_LAT_MAX) return RAM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/pc8001m_row_buffer.sv
// Double-banked 2x128x8 text row buffer: DMA writes the back bank, video reads the front bank.
// Read data is registered, valid one cycle after rd_addr.
// No backpressure; indices at or beyond ROW_BYTES read as zero.
module pc8001m_row_buffer
    import pc8001m_pkg::*;
#(
    parameter int ROW_BYTES = ROW_BYTES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [6:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic       front_bank,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [256];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_idx}] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 8'h00;
        end else if ({1'b0, rd_addr} >= 8'(ROW_BYTES)) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[{front_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/pc8001m_vram_arbiter.sv
// Shares main RAM between the Z80 and CRTC row DMA; PC8001M_CPU_INTERLEAVE_EN lets the CPU steal slots mid-row.
// Row done ROW_BYTES+RAM_LAT+1 cycles after dma_start; CPU ack RAM_LAT+1 cycles after request from idle.
// CPU is held off with cpu_wait while the bus is busy; dma_start during a fetch is dropped with dma_overrun.
module pc8001m_vram_arbiter
    import pc8001m_pkg::*;
#(
    parameter int ROW_BYTES = ROW_BYTES_DEF,
    parameter int RAM_LAT   = RAM_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_start,
    input  logic [15:0] dma_base,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        dma_overrun,
    input  logic        row_swap,
    input  logic [6:0]  rb_addr,
    output logic [7:0]  rb_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam int LAT = clamp_lat(RAM_LAT);

    state_t      state;
    logic [15:0] dma_addr;
    logic [7:0]  issue_cnt;
    logic [1:0]  run_cnt;
    logic        dma_pend;
    logic        wr_bank;
    logic        front_bank;
    logic        iss_dma;
    logic        iss_cpu;
    logic [6:0]  iss_idx;
    logic [LAT:1] dma_vld_q;
    logic [LAT:1] cpu_vld_q;
    logic [6:0]  dma_idx_q [1:LAT];

    logic        start_acc;
    logic        cpu_rq;
    logic        take_dma;
    logic        take_cpu;
    logic        slot_ok;
    logic        rd_outstanding;
    logic [15:0] iss_addr;
    logic [7:0]  iss_cnt;
    logic [7:0]  iss_cnt_nxt;
    logic [1:0]  run_nxt;

`ifdef PC8001M_CPU_INTERLEAVE_EN
    assign slot_ok = (run_cnt == 2'd3);
`else
    assign slot_ok = 1'b0;
`endif

    assign cpu_ack   = cpu_vld_q[LAT];
    assign cpu_rdata = cpu_ack ? ram_rdata : 8'h00;
    assign cpu_wait  = cpu_req & ~cpu_ack;

    always_comb begin
        start_acc = dma_start & ~dma_busy;
        cpu_rq    = cpu_req & ~cpu_ack;
        take_dma  = 1'b0;
        take_cpu  = 1'b0;
        case (state)
            ST_IDLE: begin
                take_dma = start_acc | dma_pend;
                take_cpu = ~take_dma & cpu_rq;
            end
            ST_CWAIT: take_dma = cpu_ack & dma_pend;
            ST_DMA: begin
                take_cpu = dma_pend & slot_ok & cpu_rq;
                take_dma = dma_pend & ~take_cpu;
            end
            default: ;
        endcase
        // A start accepted in IDLE issues straight from the port, skipping the latch.
        iss_addr    = (state == ST_IDLE && start_acc) ? dma_base : dma_addr;
        iss_cnt     = (state == ST_IDLE && start_acc) ? 8'd0 : issue_cnt;
        iss_cnt_nxt = iss_cnt + 8'd1;
        run_nxt     = (state == ST_IDLE) ? 2'd1 :
                      (run_cnt == 2'd3) ? 2'd3 : run_cnt + 2'd1;
        rd_outstanding = iss_dma;
        for (int j = 1; j < LAT; j++) rd_outstanding = rd_outstanding | dma_vld_q[j];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dma_addr    <= 16'h0000;
            issue_cnt   <= 8'd0;
            run_cnt     <= 2'd0;
            dma_pend    <= 1'b0;
            dma_busy    <= 1'b0;
            dma_done    <= 1'b0;
            dma_overrun <= 1'b0;
            wr_bank     <= 1'b0;
            front_bank  <= 1'b0;
            iss_dma     <= 1'b0;
            iss_cpu     <= 1'b0;
            iss_idx     <= 7'd0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= 16'h0000;
            ram_wdata   <= 8'h00;
        end else begin
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            iss_dma     <= 1'b0;
            iss_cpu     <= 1'b0;
            dma_done    <= 1'b0;
            dma_overrun <= 1'b0;
            front_bank  <= front_bank ^ row_swap;
            if (dma_done) dma_busy <= 1'b0;
            if (dma_start && dma_busy) dma_overrun <= 1'b1;
            if (start_acc) begin
                dma_busy  <= 1'b1;
                wr_bank   <= ~front_bank;
                dma_addr  <= dma_base;
                issue_cnt <= 8'd0;
                run_cnt   <= 2'd0;
                dma_pend  <= 1'b1;
            end
            if (take_dma) begin
                ram_cs    <= 1'b1;
                ram_addr  <= iss_addr;
                iss_dma   <= 1'b1;
                iss_idx   <= iss_cnt[6:0];
                dma_addr  <= iss_addr + 16'd1;
                issue_cnt <= iss_cnt_nxt;
                dma_pend  <= (iss_cnt_nxt != 8'(ROW_BYTES));
                run_cnt   <= run_nxt;
                state     <= ST_DMA;
            end else if (take_cpu) begin
                ram_cs    <= 1'b1;
                ram_we    <= cpu_we;
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
                iss_cpu   <= 1'b1;
                run_cnt   <= 2'd0;
                state     <= ST_CPU;
            end else begin
                case (state)
                    ST_CPU:   state <= ST_CWAIT;
                    ST_CWAIT: if (cpu_ack) state <= ST_IDLE;
                    ST_DMA:   state <= ST_DRAIN;
                    ST_DRAIN: begin
                        if (!rd_outstanding) begin
                            state    <= ST_IDLE;
                            dma_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read tags travel alongside the RAM pipeline so each byte lands at its own index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_vld_q <= '0;
            cpu_vld_q <= '0;
        end else begin
            dma_vld_q[1] <= iss_dma;
            cpu_vld_q[1] <= iss_cpu;
            for (int j = 2; j <= LAT; j++) begin
                dma_vld_q[j] <= dma_vld_q[j-1];
                cpu_vld_q[j] <= cpu_vld_q[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dma_idx_q[1] <= iss_idx;
        for (int j = 2; j <= LAT; j++) dma_idx_q[j] <= dma_idx_q[j-1];
    end

    pc8001m_row_buffer #(
        .ROW_BYTES (ROW_BYTES)
    ) u_row_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (dma_vld_q[LAT]),
        .wr_bank    (wr_bank),
        .wr_idx     (dma_idx_q[LAT]),
        .wr_data    (ram_rdata),
        .front_bank (front_bank),
        .rd_addr    (rb_addr),
        .rd_data    (rb_data)
    );

endmodule

// File: tb/tb_pc8001m_vram_arbiter.sv
// Directed bench for pc8001m_vram_arbiter with a 64 KiB single-cycle-latency RAM model holding addr[7:0].
// Expected CPU/DMA timings depend on PC8001M_CPU_INTERLEAVE_EN.
module tb_pc8001m_vram_arbiter;

`ifdef PC8001M_CPU_INTERLEAVE_EN
    localparam int   T3_ACK = 7,   T3_DONE = 124, T4_ACK = 5,   T4_DONE = 124;
    localparam logic WAIT_AT_DONE = 1'b0;
`else
    localparam int   T3_ACK = 124, T3_DONE = 122, T4_ACK = 124, T4_DONE = 122;
    localparam logic WAIT_AT_DONE = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dma_start;
    logic [15:0] dma_base;
    logic        dma_busy, dma_done, dma_overrun;
    logic        row_swap;
    logic [6:0]  rb_addr;
    logic [7:0]  rb_data;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_wait;
    logic        ram_cs, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  mem [65536];

    int vecs = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc8001m_vram_arbiter #(.ROW_BYTES(120), .RAM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .dma_start(dma_start), .dma_base(dma_base), .dma_busy(dma_busy),
        .dma_done(dma_done), .dma_overrun(dma_overrun), .row_swap(row_swap),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial for (int a = 0; a < 65536; a++) mem[a] = 8'(a);

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!dma_done && n < 400) begin
            tick;
            n++;
        end
    endtask

    initial begin
        int n, ack_n, done_n, done_cnt;
        logic seen_ack, seen_done, busy_seen;

        reset_n = 1'b0; dma_start = 1'b0; dma_base = 16'h0000; row_swap = 1'b0;
        rb_addr = 7'd0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        #12;
        check("reset_ctl", {dma_busy, dma_done, dma_overrun, cpu_ack, cpu_wait, ram_cs, ram_we}, 0);
        check("reset_data", {ram_addr, ram_wdata, cpu_rdata}, 0);
        check("reset_rb", rb_data, 0);
        reset_n = 1'b1;
        tick;

        // Row fetch from 0xF300, swapped in together with dma_done.
        dma_start = 1'b1; dma_base = 16'hF300;
        tick;
        dma_start = 1'b0;
        check("t1_first_cs", {ram_cs, ram_we, ram_addr}, {2'b10, 16'hF300});
        check("t1_busy", dma_busy, 1);
        wait_done(1, n);
        check("t1_done_cycle", n, 122);
        check("t1_busy_at_done", dma_busy, 1);
        row_swap = 1'b1;
        tick;
        row_swap = 1'b0;
        check("t1_idle_after", {dma_busy, dma_done}, 0);
        for (int i = 0; i < 120; i++) begin
            rb_addr = 7'(i);
            tick;
            check("t1_rb", rb_data, 32'(i));
        end
        rb_addr = 7'd127; tick; check("t1_rb127", rb_data, 0);
        rb_addr = 7'd120; tick; check("t1_rb120", rb_data, 0);

        // Address wrap from 0xFFC0.
        dma_start = 1'b1; dma_base = 16'hFFC0;
        tick;
        dma_start = 1'b0;
        wait_done(1, n);
        check("t2_done_cycle", n, 122);
        row_swap = 1'b1;
        tick;
        row_swap = 1'b0;
        rb_addr = 7'd0;   tick; check("t2_rb0", rb_data, 8'hC0);
        rb_addr = 7'd63;  tick; check("t2_rb63", rb_data, 8'hFF);
        rb_addr = 7'd64;  tick; check("t2_rb64", rb_data, 8'h00);
        rb_addr = 7'd119; tick; check("t2_rb119", rb_data, 8'h37);

        // CPU read of 0x1234 arriving 5 cycles into a fetch.
        dma_start = 1'b1; dma_base = 16'h4000;
        tick;
        dma_start = 1'b0;
        repeat (4) tick;
        n = 5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        #1;
        check("t3_wait_raised", cpu_wait, 1);
        seen_ack = 1'b0; seen_done = 1'b0; ack_n = 0; done_n = 0;
        while (!(seen_ack && seen_done) && n < 400) begin
            tick;
            n++;
            if (dma_done && !seen_done) begin
                seen_done = 1'b1; done_n = n;
                check("t3_wait_at_done", cpu_wait, WAIT_AT_DONE);
            end
            if (cpu_ack && !seen_ack) begin
                seen_ack = 1'b1; ack_n = n;
                check("t3_rdata", cpu_rdata, 8'h34);
                cpu_req = 1'b0;
            end
        end
        check("t3_ack_cycle", ack_n, T3_ACK);
        check("t3_done_cycle", done_n, T3_DONE);
        tick;

        // Simultaneous dma_start and cpu_req; second dma_start at cycle 10 overruns.
        dma_start = 1'b1; dma_base = 16'h2000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick;
        dma_start = 1'b0;
        check("t4_dma_wins", {ram_cs, ram_addr}, {1'b1, 16'h2000});
        n = 1;
        seen_ack = 1'b0; seen_done = 1'b0; ack_n = 0; done_n = 0;
        while (!(seen_ack && seen_done) && n < 400) begin
            dma_start = (n == 10);
            if (n == 10) dma_base = 16'h5555;
            tick;
            n++;
            if (n == 11) check("t4_overrun", dma_overrun, 1);
            if (n == 12) check("t4_overrun_pulse", dma_overrun, 0);
            if (dma_done && !seen_done) begin
                seen_done = 1'b1; done_n = n;
            end
            if (cpu_ack && !seen_ack) begin
                seen_ack = 1'b1; ack_n = n;
                check("t4_rdata", cpu_rdata, 8'h34);
                cpu_req = 1'b0;
            end
        end
        dma_start = 1'b0;
        check("t4_ack_cycle", ack_n, T4_ACK);
        check("t4_done_cycle", done_n, T4_DONE);
        tick;

        // Reset at cycle 50 of a fetch.
        dma_start = 1'b1; dma_base = 16'h0000;
        tick;
        dma_start = 1'b0;
        repeat (49) tick;
        check("t5_busy_before_reset", dma_busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_ctl", {dma_busy, dma_done, dma_overrun, cpu_ack, cpu_wait, ram_cs, ram_we}, 0);
        check("t5_async_data", {ram_addr, ram_wdata, cpu_rdata, rb_data}, 0);
        tick;
        tick;
        reset_n = 1'b1;
        done_cnt = 0; busy_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (dma_done) done_cnt++;
            if (dma_busy) busy_seen = 1'b1;
        end
        check("t5_no_done", done_cnt, 0);
        check("t5_no_busy", busy_seen, 0);

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'hA5;
        tick;
        check("t5_wr_cs", {ram_cs, ram_we, ram_addr, ram_wdata}, {2'b11, 16'h8000, 8'hA5});
        check("t5_wr_wait", cpu_wait, 1);
        tick;
        check("t5_wr_ack", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick;
        check("t5_ack_pulse", cpu_ack, 0);
        cpu_req = 1'b1;
        tick;
        check("t5_rd_cs", {ram_cs, ram_we, ram_addr}, {2'b10, 16'h8000});
        tick;
        check("t5_rd_ack", cpu_ack, 1);
        check("t5_rd_data", cpu_rdata, 8'hA5);
        cpu_req = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
